west_issue_ctrl: RTL

WEST_ISSUE_CTRL -- requirements
Module: west_issue_ctrl

---
 rtl/west_issue_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/west_issue_ctrl.sv
// West-edge issue controller: sequences load/execute/flush beats into a
// systolic tile and skews each row's stream diagonally by its row index.
module west_issue_ctrl #(
  parameter int bw  = 4,
  parameter int row = 8,
  parameter int col = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_os,
  input  logic [7:0]          k_len,
  input  logic [7:0]          ex_len,
  input  logic                in_valid,
  input  logic [row*bw-1:0]   in_data,
  output logic                in_ready,
  output logic [row*bw-1:0]   out_w,
  output logic [row-1:0]      out_w_zero,
  output logic [row*3-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, FLUSH, DRAIN} state_e;

  localparam logic [2:0] INST_NONE  = 3'b000;
  localparam logic [2:0] INST_LOAD  = 3'b001;
  localparam logic [2:0] INST_EXEC  = 3'b010;
  localparam logic [2:0] INST_FLUSH = 3'b100;
  localparam logic [7:0] COL_LAST   = 8'(col - 1);
  localparam logic [7:0] ROW_LAST   = 8'(row - 1);

  state_e     state_q;
  logic       is_os_q;
  logic [7:0] k_len_q;
  logic [7:0] ex_len_q;
  logic [7:0] cnt_q;
  logic       done_q;

  logic       accept;
  logic [2:0] issue_inst;
  logic       issue_force_zero;

  assign in_ready = (state_q == LOAD) || (state_q == EXEC);
  assign accept   = in_ready && in_valid;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  function automatic state_e after_exec(input logic os);
    return os ? FLUSH : DRAIN;
  endfunction

  function automatic state_e after_load(input logic [7:0] ex, input logic os);
    return (ex != 8'd0) ? EXEC : after_exec(os);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    issue_inst       = INST_NONE;
    issue_force_zero = 1'b0;
    unique case (state_q)
      LOAD: begin
        issue_inst       = in_valid ? INST_LOAD : INST_NONE;
        issue_force_zero = !in_valid;
      end
      EXEC: begin
        issue_inst       = in_valid ? INST_EXEC : INST_NONE;
        issue_force_zero = !in_valid;
      end
      FLUSH: begin
        issue_inst       = INST_FLUSH;
        issue_force_zero = 1'b1;
      end
      DRAIN:   issue_force_zero = 1'b1;
      default: ;
    endcase
  end

  // One shared 8-bit counter tracks beats within whichever phase is active.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      is_os_q  <= 1'b0;
      k_len_q  <= 8'd0;
      ex_len_q <= 8'd0;
      cnt_q    <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          is_os_q  <= is_os;
          k_len_q  <= k_len;
          ex_len_q <= ex_len;
          cnt_q    <= 8'd0;
          state_q  <= (k_len != 8'd0) ? LOAD : after_load(ex_len, is_os);
        end
        LOAD: if (in_valid) begin
          if (cnt_q == k_len_q - 8'd1) begin
            cnt_q   <= 8'd0;
            state_q <= after_load(ex_len_q, is_os_q);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        EXEC: if (in_valid) begin
          if (cnt_q == ex_len_q - 8'd1) begin
            cnt_q   <= 8'd0;
            state_q <= after_exec(is_os_q);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        FLUSH: begin
          if (cnt_q == COL_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt_q == ROW_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row r keeps only its own slice, delayed through r+1 registers: {inst, zero, data}.
  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw-1:0] elem;
    logic          elem_zero;
    logic [bw+3:0] dly_q [r+1];

    assign elem      = accept ? in_data[r*bw +: bw] : '0;
    assign elem_zero = issue_force_zero || (accept && (elem == '0));

    always_ff @(posedge clk) begin
      // NOTE: the skew array is reset on purpose: an aborted job must not leak beats into the tile.
      if (reset) begin
        for (int k = 0; k <= r; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= {issue_inst, elem_zero, elem};
        for (int k = 1; k <= r; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign out_w[r*bw +: bw] = dly_q[r][bw-1:0];
    assign out_w_zero[r]     = dly_q[r][bw];
    assign inst_w[r*3 +: 3]  = dly_q[r][bw+3:bw+1];
  end

endmodule
